// File: rtl/bp_pkg.sv
// Shared types for the gshare predictor: 2-bit counter states, reset value and
// BTB entry layout.
package bp_pkg;

    localparam int unsigned BP_PC_W = 5;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam logic [1:0] PHT_INIT = 2'b01;

    typedef struct packed {
        logic               valid;
        logic [BP_PC_W-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter_2b.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter_2b
    import bp_pkg::*;
(
    input  logic taken,
    input  ctr_t cur,
    output ctr_t nxt
);

    logic [1:0] cur_v;

    always_comb begin
        cur_v = cur;
        nxt   = cur;
        if (taken) begin
            if (cur != ST) nxt = ctr_t'(cur_v + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur_v - 2'd1);
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage gshare direction predictor with a direct-mapped BTB and a
// speculatively shifted global history register repaired from execute.
module gshare_branch_predictor #(
    parameter int unsigned PC_W     = bp_pkg::BP_PC_W,
    parameter int unsigned GHR_W    = PC_W,
    parameter logic [1:0]  PHT_INIT = bp_pkg::PHT_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [PC_W-1:0]  PC_F,
    output logic             prediction_F,
    output logic [PC_W-1:0]  BTA_F,
    output logic [GHR_W-1:0] ghr_F,
    output logic             btb_hit_F,
    input  logic             update_E,
    input  logic [PC_W-1:0]  PC_E,
    input  logic [GHR_W-1:0] ghr_E,
    input  logic             taken_E,
    input  logic [PC_W-1:0]  target_E,
    input  logic             mispredict_E
);

    import bp_pkg::*;

    localparam int unsigned DEPTH = 2 ** PC_W;

    ctr_t             pht_q [DEPTH];
    btb_entry_t       btb_q [DEPTH];
    logic [GHR_W-1:0] ghr_q, ghr_d;

    logic [PC_W-1:0]  idx_F, idx_E;
    btb_entry_t       btb_rd;
    ctr_t             pht_rd;
    ctr_t             pht_upd_cur, pht_upd_nxt;
    logic             repair;

    assign idx_F  = PC_F ^ ghr_q;
    assign idx_E  = PC_E ^ ghr_E;
    assign btb_rd = btb_q[PC_F];
    assign pht_rd = pht_q[idx_F];

    assign btb_hit_F    = btb_rd.valid;
    assign prediction_F = btb_rd.valid & pht_rd[1];
    assign BTA_F        = btb_rd.target;
    assign ghr_F        = ghr_q;

    assign pht_upd_cur = pht_q[idx_E];

    sat_counter_2b u_sat (
        .taken (taken_E),
        .cur   (pht_upd_cur),
        .nxt   (pht_upd_nxt)
    );

    // Repair wins over both stall and the speculative shift.
    assign repair = update_E & mispredict_E;

    always_comb begin
        ghr_d = ghr_q;
        if (repair) begin
            ghr_d = {ghr_E[GHR_W-2:0], taken_E};
        end else if (btb_hit_F && !stall) begin
            ghr_d = {ghr_q[GHR_W-2:0], prediction_F};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ghr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pht_q[i] <= ctr_t'(PHT_INIT);
                btb_q[i] <= '0;
            end
        end else begin
            ghr_q <= ghr_d;
            if (update_E) begin
                pht_q[idx_E] <= pht_upd_nxt;
                if (taken_E) begin
                    btb_q[PC_E] <= '{valid: 1'b1, target: target_E};
                end
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench: the driver queues hand-computed lookup results, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_gshare_branch_predictor;

    logic       clk = 1'b0;
    logic       reset, stall, update_E, taken_E, mispredict_E;
    logic [4:0] PC_F, PC_E, ghr_E, target_E;
    logic       prediction_F, btb_hit_F;
    logic [4:0] BTA_F, ghr_F;
    logic       mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic       pred;
        logic       hit;
        logic [4:0] bta;
        logic [4:0] ghr;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    gshare_branch_predictor #(.PC_W(5), .GHR_W(5), .PHT_INIT(2'b01)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .PC_F         (PC_F),
        .prediction_F (prediction_F),
        .BTA_F        (BTA_F),
        .ghr_F        (ghr_F),
        .btb_hit_F    (btb_hit_F),
        .update_E     (update_E),
        .PC_E         (PC_E),
        .ghr_E        (ghr_E),
        .taken_E      (taken_E),
        .target_E     (target_E),
        .mispredict_E (mispredict_E)
    );

    task automatic cmp(input string nm, input string field, input logic [4:0] act, input logic [4:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %b expected %b", nm, field, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: output presented with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.nm, "prediction_F", {4'b0, prediction_F}, {4'b0, e.pred});
                cmp(e.nm, "btb_hit_F",    {4'b0, btb_hit_F},    {4'b0, e.hit});
                cmp(e.nm, "BTA_F",        BTA_F,                e.bta);
                cmp(e.nm, "ghr_F",        ghr_F,                e.ghr);
            end
        end
    end

    // One cycle: drive inputs, optionally queue the expected lookup, advance.
    task automatic step(
        input logic rst, input logic stl, input logic [4:0] pcf,
        input logic upd, input logic [4:0] pce, input logic [4:0] ghre,
        input logic tkn, input logic [4:0] tgt, input logic mis,
        input bit chk, input string nm,
        input logic ep, input logic eh, input logic [4:0] eb, input logic [4:0] eg);
        exp_t e;
        reset = rst; stall = stl; PC_F = pcf;
        update_E = upd; PC_E = pce; ghr_E = ghre;
        taken_E = tkn; target_E = tgt; mispredict_E = mis;
        if (chk) begin
            e.nm = nm; e.pred = ep; e.hit = eh; e.bta = eb; e.ghr = eg;
            exp_q.push_back(e);
        end
        mon_en = chk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; PC_F = '0; update_E = 1'b0; PC_E = '0;
        ghr_E = '0; taken_E = 1'b0; target_E = '0; mispredict_E = 1'b0;
        #2;
        //   rst stl pcf    upd pce    ghre      tkn tgt    mis chk name          pred hit bta    ghr
        step(0, 0, 5'h00, 0, 5'h00, 5'h00,    0, 5'h00, 0, 0, "",            0, 0, 5'h00, 5'h00);
        step(0, 0, 5'h03, 1, 5'h03, 5'h00,    1, 5'h10, 1, 0, "",            0, 0, 5'h00, 5'h00);
        step(1, 0, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "reset",       0, 0, 5'h00, 5'h00);
        // training to taken
        step(1, 0, 5'h03, 1, 5'h03, 5'h00,    1, 5'h10, 1, 1, "train1",      0, 0, 5'h00, 5'h00);
        step(1, 0, 5'h00, 1, 5'h03, 5'h00,    1, 5'h10, 1, 1, "train2_ghr",  0, 0, 5'h00, 5'h01);
        step(1, 1, 5'h03, 1, 5'h14, 5'h00,    0, 5'h00, 1, 1, "stall_rep",   0, 1, 5'h10, 5'h01);
        step(1, 1, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "trained",     1, 1, 5'h10, 5'h00);
        // saturation
        step(1, 1, 5'h03, 1, 5'h03, 5'h00,    1, 5'h10, 0, 1, "sat1",        1, 1, 5'h10, 5'h00);
        step(1, 1, 5'h03, 1, 5'h03, 5'h00,    1, 5'h10, 0, 1, "sat2",        1, 1, 5'h10, 5'h00);
        step(1, 1, 5'h03, 1, 5'h03, 5'h00,    1, 5'h10, 0, 1, "sat3",        1, 1, 5'h10, 5'h00);
        step(1, 1, 5'h03, 1, 5'h03, 5'h00,    0, 5'h00, 0, 1, "sat_st",      1, 1, 5'h10, 5'h00);
        step(1, 1, 5'h03, 1, 5'h03, 5'h00,    0, 5'h00, 0, 1, "sat_wt",      1, 1, 5'h10, 5'h00);
        step(1, 1, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "sat_wnt",     0, 1, 5'h10, 5'h00);
        // prime PHT[3], PHT[2], PHT[0] to weakly taken for the shift test
        step(1, 1, 5'h00, 1, 5'h03, 5'h00,    1, 5'h10, 0, 1, "prime0",      0, 0, 5'h00, 5'h00);
        step(1, 1, 5'h00, 1, 5'h03, 5'h01,    1, 5'h10, 0, 0, "",            0, 0, 5'h00, 5'h00);
        step(1, 1, 5'h00, 1, 5'h03, 5'h03,    1, 5'h10, 0, 0, "",            0, 0, 5'h00, 5'h00);
        // speculative shift and stall
        step(1, 0, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "spec1",       1, 1, 5'h10, 5'h00);
        step(1, 0, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "spec2",       1, 1, 5'h10, 5'h01);
        step(1, 0, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "spec3",       1, 1, 5'h10, 5'h03);
        step(1, 1, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "stall_hold",  0, 1, 5'h10, 5'h07);
        // repair priority over an unstalled BTB hit
        step(1, 0, 5'h03, 1, 5'h09, 5'b01010, 1, 5'h1F, 1, 1, "rep_oldghr",  0, 1, 5'h10, 5'h07);
        step(1, 1, 5'h09, 1, 5'h14, 5'h00,    0, 5'h00, 1, 1, "rep_newghr",  0, 1, 5'h1F, 5'b10101);
        // read-before-write on PC 7
        step(1, 1, 5'h07, 1, 5'h07, 5'h00,    1, 5'h0A, 0, 1, "rbw_btb",     0, 0, 5'h00, 5'h00);
        step(1, 1, 5'h07, 1, 5'h07, 5'h00,    0, 5'h00, 0, 1, "rbw_pht",     1, 1, 5'h0A, 5'h00);
        step(1, 1, 5'h07, 0, 5'h00, 5'h1F,    1, 5'h00, 1, 1, "nt_keep_btb", 0, 1, 5'h0A, 5'h00);
        step(1, 1, 5'h07, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "mis_noupd",   0, 1, 5'h0A, 5'h00);
        // mid-run reset wipes training
        step(0, 0, 5'h07, 0, 5'h00, 5'h00,    0, 5'h00, 0, 0, "",            0, 0, 5'h00, 5'h00);
        step(1, 1, 5'h07, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "wipe7",       0, 0, 5'h00, 5'h00);
        step(1, 1, 5'h09, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "wipe9",       0, 0, 5'h00, 5'h00);
        step(1, 1, 5'h03, 0, 5'h00, 5'h00,    0, 5'h00, 0, 1, "wipe3",       0, 0, 5'h00, 5'h00);
        step(1, 1, 5'h00, 0, 5'h00, 5'h00,    0, 5'h00, 0, 0, "",            0, 0, 5'h00, 5'h00);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
